mem_bus_arbiter: RTL and testbench

//  Shares the single core memory port between instruction fetch (IF) and load/store (LSU) requesters.

---
 rtl/mem_bus_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single core memory port between instruction fetch (IF) and the load/store
//   unit (LSU). A registered FSM grants one requester at a time. LSU normally wins a
//   collision, but a starvation counter forces one IF grant after STARVE_LIMIT consecutive
//   LSU grants taken while IF was waiting. A per-transfer timeout converts a memory that
//   never acks into an error response to the requester.
//
// Parameters
//   STARVE_LIMIT    LSU grants allowed while IF waits before IF wins once (>= 1)
//   TIMEOUT_CYCLES  GRANT cycles without i_MEM_ACK before abort; 0 disables the timeout
//
// Ports
//   i_CLK, i_RST                 clock, synchronous active-high reset
//   i_IF_REQ / i_IF_ADDR         fetch request, word address (bits [1:0] dropped)
//   o_IF_ACK / _RDATA / _ERR     fetch completion pulse, instruction word, timeout flag
//   i_LSU_REQ/_WE/_ADDR/_WDATA/_HB  data request, direction, address, store data, size
//   o_LSU_ACK / _RDATA / _ERR    access completion pulse, load data (0 on store), timeout
//   o_MEM_REQ/_WE/_ADDR/_WDATA/_HB  bus request and its latched fields
//   i_MEM_ACK / i_MEM_RDATA      bus completion and read data
//   o_BUSY                       high whenever the FSM is not idle
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_CLK,
  input  logic        i_RST,

  input  logic        i_IF_REQ,
  input  logic [31:0] i_IF_ADDR,
  output logic        o_IF_ACK,
  output logic [31:0] o_IF_RDATA,
  output logic        o_IF_ERR,

  input  logic        i_LSU_REQ,
  input  logic        i_LSU_WE,
  input  logic [31:0] i_LSU_ADDR,
  input  logic [31:0] i_LSU_WDATA,
  input  logic [1:0]  i_LSU_HB,
  output logic        o_LSU_ACK,
  output logic [31:0] o_LSU_RDATA,
  output logic        o_LSU_ERR,

  output logic        o_MEM_REQ,
  output logic        o_MEM_WE,
  output logic [31:0] o_MEM_ADDR,
  output logic [31:0] o_MEM_WDATA,
  output logic [1:0]  o_MEM_HB,
  input  logic        i_MEM_ACK,
  input  logic [31:0] i_MEM_RDATA,

  output logic        o_BUSY
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  // Keep the timeout counter at least one bit wide even when the timeout is disabled.
  localparam int unsigned ToW     = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          ToEn    = (TIMEOUT_CYCLES != 0);

  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
  localparam logic [ToW-1:0]     ToLast    =
      ToW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGrantIf,
    StGrantLsu,
    StResp
  } state_e;

  state_e              state_q, state_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic [ToW-1:0]      to_q, to_d;

  logic                if_ack_q, if_ack_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic                if_err_q, if_err_d;
  logic                lsu_ack_q, lsu_ack_d;
  logic [31:0]         lsu_rdata_q, lsu_rdata_d;
  logic                lsu_err_q, lsu_err_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [1:0]          mem_hb_q, mem_hb_d;
  logic                busy_q, busy_d;

  // Fetches are always word aligned; the low address bits carry no information.
  logic if_addr_lsb_unused;
  assign if_addr_lsb_unused = ^i_IF_ADDR[1:0];

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    to_d        = to_q;
    if_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    if_err_d    = if_err_q;
    lsu_ack_d   = 1'b0;
    lsu_rdata_d = lsu_rdata_q;
    lsu_err_d   = lsu_err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_hb_d    = mem_hb_q;

    unique case (state_q)
      StIdle: begin
        // IF not waiting: nothing is being starved.
        if (!i_IF_REQ) starve_d = '0;

        if (i_IF_REQ && (!i_LSU_REQ || starve_q == StarveMax)) begin
          state_d     = StGrantIf;
          starve_d    = '0;
          to_d        = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {i_IF_ADDR[31:2], 2'b00};
          mem_wdata_d = '0;
          mem_hb_d    = 2'b10;
        end else if (i_LSU_REQ) begin
          state_d     = StGrantLsu;
          to_d        = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = i_LSU_WE;
          mem_addr_d  = i_LSU_ADDR;
          mem_wdata_d = i_LSU_WDATA;
          mem_hb_d    = i_LSU_HB;
          if (i_IF_REQ && starve_q != StarveMax) starve_d = starve_q + 1'b1;
        end
      end

      StGrantIf, StGrantLsu: begin
        if (i_MEM_ACK) begin
          state_d   = StResp;
          mem_req_d = 1'b0;
          if (state_q == StGrantIf) begin
            if_ack_d   = 1'b1;
            if_rdata_d = i_MEM_RDATA;
            if_err_d   = 1'b0;
          end else begin
            lsu_ack_d   = 1'b1;
            lsu_rdata_d = mem_we_q ? 32'h0 : i_MEM_RDATA;
            lsu_err_d   = 1'b0;
          end
        end else if (ToEn && to_q == ToLast) begin
          // Memory never answered: release the bus and report an error.
          state_d   = StResp;
          mem_req_d = 1'b0;
          if (state_q == StGrantIf) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
            if_err_d   = 1'b1;
          end else begin
            lsu_ack_d   = 1'b1;
            lsu_rdata_d = '0;
            lsu_err_d   = 1'b1;
          end
        end else if (ToEn) begin
          to_d = to_q + 1'b1;
        end
      end

      // One dead cycle so the requester can drop or change its request.
      StResp: state_d = StIdle;

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      to_q        <= '0;
      if_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      lsu_ack_q   <= 1'b0;
      lsu_rdata_q <= '0;
      lsu_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_hb_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      to_q        <= to_d;
      if_ack_q    <= if_ack_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      lsu_ack_q   <= lsu_ack_d;
      lsu_rdata_q <= lsu_rdata_d;
      lsu_err_q   <= lsu_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_hb_q    <= mem_hb_d;
      busy_q      <= busy_d;
    end
  end

  assign o_IF_ACK    = if_ack_q;
  assign o_IF_RDATA  = if_rdata_q;
  assign o_IF_ERR    = if_err_q;
  assign o_LSU_ACK   = lsu_ack_q;
  assign o_LSU_RDATA = lsu_rdata_q;
  assign o_LSU_ERR   = lsu_err_q;
  assign o_MEM_REQ   = mem_req_q;
  assign o_MEM_WE    = mem_we_q;
  assign o_MEM_ADDR  = mem_addr_q;
  assign o_MEM_WDATA = mem_wdata_q;
  assign o_MEM_HB    = mem_hb_q;
  assign o_BUSY      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed steps plus a scoreboard of expected responses.
// A second instance with the timeout disabled shares all inputs.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_req, lsu_req, lsu_we, mem_ack;
  logic [31:0] if_addr, lsu_addr, lsu_wdata, mem_rdata;
  logic [1:0]  lsu_hb;
  logic        if_ack, if_err, lsu_ack, lsu_err, mem_req, mem_we, busy;
  logic [31:0] if_rdata, lsu_rdata, mem_addr, mem_wdata;
  logic [1:0]  mem_hb;
  logic        z_if_ack, z_if_err, z_lsu_ack, z_lsu_err, z_mem_req, z_mem_we, z_busy;
  logic [31:0] z_if_rdata, z_lsu_rdata, z_mem_addr, z_mem_wdata;
  logic [1:0]  z_mem_hb;

  mem_bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .i_CLK(clk), .i_RST(rst),
    .i_IF_REQ(if_req), .i_IF_ADDR(if_addr),
    .o_IF_ACK(if_ack), .o_IF_RDATA(if_rdata), .o_IF_ERR(if_err),
    .i_LSU_REQ(lsu_req), .i_LSU_WE(lsu_we), .i_LSU_ADDR(lsu_addr),
    .i_LSU_WDATA(lsu_wdata), .i_LSU_HB(lsu_hb),
    .o_LSU_ACK(lsu_ack), .o_LSU_RDATA(lsu_rdata), .o_LSU_ERR(lsu_err),
    .o_MEM_REQ(mem_req), .o_MEM_WE(mem_we), .o_MEM_ADDR(mem_addr),
    .o_MEM_WDATA(mem_wdata), .o_MEM_HB(mem_hb),
    .i_MEM_ACK(mem_ack), .i_MEM_RDATA(mem_rdata),
    .o_BUSY(busy)
  );

  mem_bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(0)) dut_noto (
    .i_CLK(clk), .i_RST(rst),
    .i_IF_REQ(if_req), .i_IF_ADDR(if_addr),
    .o_IF_ACK(z_if_ack), .o_IF_RDATA(z_if_rdata), .o_IF_ERR(z_if_err),
    .i_LSU_REQ(lsu_req), .i_LSU_WE(lsu_we), .i_LSU_ADDR(lsu_addr),
    .i_LSU_WDATA(lsu_wdata), .i_LSU_HB(lsu_hb),
    .o_LSU_ACK(z_lsu_ack), .o_LSU_RDATA(z_lsu_rdata), .o_LSU_ERR(z_lsu_err),
    .o_MEM_REQ(z_mem_req), .o_MEM_WE(z_mem_we), .o_MEM_ADDR(z_mem_addr),
    .o_MEM_WDATA(z_mem_wdata), .o_MEM_HB(z_mem_hb),
    .i_MEM_ACK(mem_ack), .i_MEM_RDATA(mem_rdata),
    .o_BUSY(z_busy)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  hb;
  } lsu_stim_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic [31:0] if_stim[$];
  lsu_stim_t   lsu_stim[$];
  resp_t       if_exp[$];
  resp_t       lsu_exp[$];
  int          gaps[$];
  logic        grant_we[$];

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  bit          auto_on, mem_never, req_seen, mem_acked, z_ack_seen;
  int          dly_lo, dly_hi, countdown, owner, grant_len, last_len, prev_rise;
  int          grant_cyc, if_ack_cyc, if_acks, lsu_acks, ord_n;
  logic [15:0] ord_bits;
  logic [66:0] own_fields;
  logic [31:0] g_addr;
  logic [1:0]  g_hb;
  logic        g_we;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return 160'({if_ack, if_rdata, if_err, lsu_ack, lsu_rdata, lsu_err,
                 mem_req, mem_we, mem_addr, mem_wdata, mem_hb, busy});
  endfunction

  task automatic start_if();
    if (if_stim.size() > 0) begin
      if_addr = if_stim.pop_front();
      if_req  = 1'b1;
    end
  endtask

  task automatic start_lsu();
    lsu_stim_t s;
    if (lsu_stim.size() > 0) begin
      s = lsu_stim.pop_front();
      {lsu_we, lsu_addr, lsu_wdata, lsu_hb} = s;
      lsu_req = 1'b1;
    end
  endtask

  // One clock: outputs sampled 1 time unit after the edge, then requester and memory
  // models react for the following cycle.
  task automatic tick();
    logic [66:0] bus, if_f, lsu_f;
    resp_t       e;
    logic [31:0] rd;
    @(posedge clk);
    #1;
    cyc++;
    if (!auto_on) return;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (z_lsu_ack) z_ack_seen = 1'b1;

    if (if_ack) begin
      ord_bits = {ord_bits[14:0], 1'b1};
      ord_n++;
      if_acks++;
      if_ack_cyc = cyc;
      if (if_exp.size() == 0) chk("if_spurious_ack", 160'(1), 160'(0));
      else begin
        e = if_exp.pop_front();
        chk("if_rdata", 160'(if_rdata), 160'(e.rdata));
        chk("if_err", 160'(if_err), 160'(e.err));
      end
      if (if_stim.size() > 0) if_addr = if_stim.pop_front();
      else if_req = 1'b0;
    end

    if (lsu_ack) begin
      ord_bits = {ord_bits[14:0], 1'b0};
      ord_n++;
      lsu_acks++;
      if (lsu_exp.size() == 0) chk("lsu_spurious_ack", 160'(1), 160'(0));
      else begin
        e = lsu_exp.pop_front();
        chk("lsu_rdata", 160'(lsu_rdata), 160'(e.rdata));
        chk("lsu_err", 160'(lsu_err), 160'(e.err));
      end
      lsu_req = 1'b0;
      start_lsu();
    end

    bus = {mem_we, mem_hb, mem_addr, mem_wdata};
    if (!mem_req && req_seen) begin
      req_seen = 1'b0;
      last_len = grant_len;
    end
    if (mem_req && !req_seen) begin
      if_f  = {1'b0, 2'b10, if_addr[31:2], 2'b00, 32'h0};
      lsu_f = {lsu_we, lsu_hb, lsu_addr, lsu_wdata};
      if (if_req && bus === if_f) owner = 1;
      else if (lsu_req && bus === lsu_f) owner = 2;
      else owner = 0;
      own_fields = (owner == 2) ? lsu_f : if_f;
      chk("grant_fields", 160'(bus), 160'(own_fields));
      req_seen  = 1'b1;
      mem_acked = 1'b0;
      grant_len = 0;
      grant_cyc = cyc;
      g_addr = mem_addr; g_hb = mem_hb; g_we = mem_we;
      grant_we.push_back(mem_we);
      if (prev_rise >= 0) gaps.push_back(cyc - prev_rise);
      prev_rise = cyc;
      countdown = $urandom_range(dly_hi, dly_lo);
    end else if (mem_req) begin
      chk("bus_stable", 160'(bus), 160'(own_fields));
    end

    if (mem_req) begin
      grant_len++;
      if (!mem_never && !mem_acked) begin
        if (countdown == 0) begin
          rd        = $urandom;
          mem_rdata = rd;
          mem_ack   = 1'b1;
          mem_acked = 1'b1;
          if (owner == 1) if_exp.push_back({rd, 1'b0});
          else if (owner == 2) lsu_exp.push_back({own_fields[66] ? 32'h0 : rd, 1'b0});
        end else begin
          countdown--;
        end
      end
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((if_req || lsu_req || busy || if_exp.size() > 0 || lsu_exp.size() > 0)
           && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 160'(n < budget), 160'(1));
  endtask

  task automatic clear_trace();
    ord_bits = '0; ord_n = 0; prev_rise = -1; if_acks = 0; lsu_acks = 0;
    gaps.delete(); grant_we.delete();
  endtask

  initial begin
    lsu_stim_t s;
    int n;
    rst = 1'b1; if_req = 0; lsu_req = 0; lsu_we = 0; mem_ack = 0;
    if_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_hb = '0; mem_rdata = '0;
    auto_on = 0; mem_never = 0; req_seen = 0; mem_acked = 0; z_ack_seen = 0;
    dly_lo = 0; dly_hi = 0; countdown = 0; owner = 0; grant_len = 0; last_len = 0;
    grant_cyc = 0; if_ack_cyc = 0; own_fields = '0;
    clear_trace();

    // Reset state
    tick(); tick();
    chk("reset_outputs", all_outs(), 160'(0));

    // Reset mid GRANT_LSU with an ack in the same cycle
    rst = 1'b0;
    tick();
    lsu_req = 1; lsu_we = 0; lsu_addr = 32'h2040; lsu_wdata = 32'h1234; lsu_hb = 2'b10;
    n = 0;
    while (!mem_req && n < 5) begin tick(); n++; end
    chk("rst_grant_reached", 160'(mem_req), 160'(1));
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D; rst = 1;
    tick();
    chk("rst_mid_outputs", all_outs(), 160'(0));
    chk("rst_mid_noto", 160'({z_mem_req, z_busy, z_lsu_ack}), 160'(0));
    rst = 0; mem_ack = 0; lsu_req = 0;
    tick();
    chk("rst_no_late_ack", 160'({lsu_ack, busy, mem_req}), 160'(0));
    tick();
    auto_on = 1;

    // Single fetch, ack in the first grant cycle
    dly_lo = 0; dly_hi = 0;
    clear_trace();
    if_stim.push_back(32'h103);
    n = cyc;
    start_if();
    wait_done("fetch_done", 20);
    chk("fetch_grant_lat", 160'(grant_cyc - n), 160'(1));
    chk("fetch_ack_lat", 160'(if_ack_cyc - n), 160'(2));
    chk("fetch_addr", 160'(g_addr), 160'(32'h100));
    chk("fetch_hb", 160'(g_hb), 160'(2'b10));
    chk("fetch_we", 160'(g_we), 160'(0));

    // Collision: LSU store first, then IF
    clear_trace();
    s = '{we: 1'b1, addr: 32'h2000, wdata: 32'hDEAD_BEEF, hb: 2'b10};
    lsu_stim.push_back(s);
    if_stim.push_back(32'h1010);
    start_if(); start_lsu();
    wait_done("coll_done", 40);
    chk("coll_order_n", 160'(ord_n), 160'(2));
    chk("coll_order", 160'(ord_bits[1:0]), 160'(2'b01));
    chk("coll_first_we", 160'(grant_we[0]), 160'(1));
    chk("coll_second_we", 160'(grant_we[1]), 160'(0));
    chk("coll_lsu_rdata_hold", 160'(lsu_rdata), 160'(0));

    // Starvation guard: L,L,L,L,I,L,L,I with back-to-back grants
    clear_trace();
    for (int i = 0; i < 6; i++) begin
      s = '{we: 1'b0, addr: 32'h2100 + 32'(i * 4), wdata: 32'h0, hb: 2'b10};
      lsu_stim.push_back(s);
    end
    if_stim.push_back(32'h1100);
    if_stim.push_back(32'h1104);
    start_if(); start_lsu();
    wait_done("starve_done", 100);
    chk("starve_order_n", 160'(ord_n), 160'(8));
    chk("starve_order", 160'(ord_bits[7:0]), 160'(8'b0000_1001));
    chk("starve_gap_count", 160'(gaps.size()), 160'(7));
    foreach (gaps[i]) chk("starve_gap", 160'(gaps[i]), 160'(3));

    // Timeout: no memory ack
    clear_trace();
    mem_never = 1; z_ack_seen = 0;
    lsu_exp.push_back({32'h0, 1'b1});
    s = '{we: 1'b0, addr: 32'h2200, wdata: 32'h55, hb: 2'b01};
    lsu_stim.push_back(s);
    start_lsu();
    wait_done("to_done", 40);
    chk("to_grant_len", 160'(last_len), 160'(8));
    chk("to_noto_held", 160'(z_mem_req), 160'(1));
    for (int i = 0; i < 30; i++) tick();
    chk("to_noto_still_held", 160'({z_mem_req, z_busy, z_ack_seen}), 160'(3'b110));
    chk("to_err_hold", 160'(lsu_err), 160'(1));
    rst = 1; tick(); rst = 0; tick();
    chk("to_noto_reset", 160'({z_mem_req, z_busy}), 160'(0));
    mem_never = 0;

    // Variable latency, random traffic
    clear_trace();
    dly_lo = 0; dly_hi = 5;
    for (int i = 0; i < 20; i++) begin
      if_stim.push_back(32'h1000 | 32'($urandom_range(0, 32'hFFF)));
      s.we    = 1'($urandom_range(0, 1));
      s.addr  = 32'h2000 | 32'($urandom_range(0, 32'hFFF));
      s.wdata = $urandom;
      s.hb    = 2'($urandom_range(0, 2));
      lsu_stim.push_back(s);
    end
    start_if(); start_lsu();
    wait_done("rand_done", 3000);
    chk("rand_if_acks", 160'(if_acks), 160'(20));
    chk("rand_lsu_acks", 160'(lsu_acks), 160'(20));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
